// File: rtl/machine_pkg.sv
// Shared constants and types for the machine line decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package machine_pkg;

    localparam int unsigned DEFAULT_MAX_WIRING_WIDTH   = 10;
    localparam int unsigned DEFAULT_MAX_BUTTON_WIRINGS = 13;

    // ASCII bytes recognised by the parser
    localparam logic [7:0] ASCII_LBRACKET = 8'h5B;  // '['
    localparam logic [7:0] ASCII_RBRACKET = 8'h5D;  // ']'
    localparam logic [7:0] ASCII_LPAREN   = 8'h28;  // '('
    localparam logic [7:0] ASCII_RPAREN   = 8'h29;  // ')'
    localparam logic [7:0] ASCII_LBRACE   = 8'h7B;  // '{'
    localparam logic [7:0] ASCII_RBRACE   = 8'h7D;  // '}'
    localparam logic [7:0] ASCII_COMMA    = 8'h2C;  // ','
    localparam logic [7:0] ASCII_DOT      = 8'h2E;  // '.'
    localparam logic [7:0] ASCII_HASH     = 8'h23;  // '#'
    localparam logic [7:0] ASCII_LF       = 8'h0A;  // '\n'
    localparam logic [7:0] ASCII_CR       = 8'h0D;  // '\r'
    localparam logic [7:0] ASCII_SPACE    = 8'h20;  // ' '
    localparam logic [7:0] ASCII_ZERO     = 8'h30;  // '0'
    localparam logic [7:0] ASCII_NINE     = 8'h39;  // '9'

    typedef enum logic [2:0] {
        LINE_START,
        LIGHTS,
        GAP,
        BUTTON,
        JOLTAGE,
        DONE
    } decoder_state_t;

endpackage

// File: rtl/ascii_decimal_accumulator.sv
// Decimal accumulator for button indices: acc = acc*10 + digit, saturating at 255.
// Latency: accumulated value visible the cycle after the digit is accepted.
// Backpressure: none; every qualified byte is consumed.
module ascii_decimal_accumulator
    import machine_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic       i_enable,
    input  logic       i_clear,
    input  logic [7:0] i_data,
    output logic       o_is_digit,
    output logic [7:0] o_acc,
    output logic       o_has_digit
);

    logic [7:0]  r_acc;
    logic        r_has_digit;
    logic [11:0] w_sum;

    assign o_is_digit  = (i_data >= ASCII_ZERO) && (i_data <= ASCII_NINE);
    // low nibble of an ASCII digit is its value
    assign w_sum       = 12'(r_acc) * 12'd10 + 12'(i_data[3:0]);
    assign o_acc       = r_acc;
    assign o_has_digit = r_has_digit;

    // accumulate digits, clear on separators, saturate on overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= 8'd0;
            r_has_digit <= 1'b0;
        end else if (i_valid && i_clear) begin
            r_acc       <= 8'd0;
            r_has_digit <= 1'b0;
        end else if (i_valid && i_enable && o_is_digit) begin
            r_acc       <= (w_sum > 12'd255) ? 8'hFF : w_sum[7:0];
            r_has_digit <= 1'b1;
        end
    end

endmodule

// File: rtl/machine_line_decoder.sv
// Parses ASCII machine lines into a target word followed by one mask per button.
// Latency: each output appears 1 cycle after its causing byte (line close after a final word: +2).
// Backpressure: none; input is always accepted, DONE swallows everything until rst.
module machine_line_decoder
    import machine_pkg::*;
#(
    parameter int MAX_WIRING_WIDTH   = DEFAULT_MAX_WIRING_WIDTH,
    parameter int MAX_BUTTON_WIRINGS = DEFAULT_MAX_BUTTON_WIRINGS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        inbound_valid,
    input  logic [7:0]                  inbound_data,
    input  logic                        inbound_last,
    output logic                        end_of_file,
    output logic                        end_of_line,
    output logic                        wiring_valid,
    output logic [MAX_WIRING_WIDTH-1:0] wiring_data,
    output logic                        decode_error
);

    localparam int IDX_W = $clog2(MAX_WIRING_WIDTH + 1);
    typedef logic [MAX_WIRING_WIDTH-1:0] wiring_t;

    localparam logic [IDX_W-1:0] LIGHT_LIMIT = IDX_W'(MAX_WIRING_WIDTH);
    localparam logic [7:0]       ACC_LIMIT   = 8'(MAX_WIRING_WIDTH);
    localparam logic [7:0]       BTN_LIMIT   = 8'(MAX_BUTTON_WIRINGS);

    decoder_state_t   r_state;
    logic [IDX_W-1:0] r_light_idx;
    wiring_t          r_mask;
    logic [7:0]       r_btn_cnt;
    logic             r_emitted;
    logic             r_eol_pend;
    logic             r_eof_pend;
    logic             r_eof;
    logic             r_eol;
    logic             r_wvld;
    wiring_t          r_wdat;
    logic             r_err;

    logic             w_byte_vld;
    logic             w_is_digit;
    logic [7:0]       w_acc;
    logic             w_has_digit;
    logic             w_acc_clear;
    logic             w_index_ok;
    wiring_t          w_index_bit;
    wiring_t          w_light_bit;
    logic             w_emit_word;
    logic             w_closes_line;
    logic             w_line_open;

    assign w_byte_vld  = inbound_valid && (r_state != DONE);
    assign w_acc_clear = ((r_state == GAP) && (inbound_data == ASCII_LPAREN)) ||
                         ((r_state == BUTTON) &&
                          ((inbound_data == ASCII_COMMA) || (inbound_data == ASCII_RPAREN)));

    ascii_decimal_accumulator u_acc (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (w_byte_vld),
        .i_enable    (r_state == BUTTON),
        .i_clear     (w_acc_clear),
        .i_data      (inbound_data),
        .o_is_digit  (w_is_digit),
        .o_acc       (w_acc),
        .o_has_digit (w_has_digit)
    );

    // an index is usable only if digits were seen and it names an existing light
    assign w_index_ok  = w_has_digit && (w_acc < ACC_LIMIT);
    assign w_index_bit = w_index_ok ? (wiring_t'(1) << w_acc) : '0;
    assign w_light_bit = wiring_t'(1) << r_light_idx;

    // line-level bookkeeping needed when the final byte of the file arrives
    assign w_emit_word   = ((r_state == LIGHTS) && (inbound_data == ASCII_RBRACKET)) ||
                           ((r_state == BUTTON) && (inbound_data == ASCII_RPAREN));
    assign w_closes_line = ((r_state == LINE_START) || (r_state == GAP)) &&
                           (inbound_data == ASCII_LF);
    assign w_line_open   = (r_emitted || w_emit_word) && !w_closes_line;

    // parser FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LINE_START;
            r_light_idx <= '0;
            r_mask      <= '0;
            r_btn_cnt   <= 8'd0;
            r_emitted   <= 1'b0;
            r_eol_pend  <= 1'b0;
            r_eof_pend  <= 1'b0;
            r_eof       <= 1'b0;
            r_eol       <= 1'b0;
            r_wvld      <= 1'b0;
            r_wdat      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_wvld <= 1'b0;
            r_eol  <= 1'b0;
            r_eof  <= 1'b0;
            // deferred line/file closure after a final word on an unterminated line
            if (r_eol_pend) begin
                r_eol      <= 1'b1;
                r_eol_pend <= 1'b0;
                r_eof_pend <= 1'b1;
            end
            if (r_eof_pend) begin
                r_eof      <= 1'b1;
                r_eof_pend <= 1'b0;
            end
            if (w_byte_vld) begin
                case (r_state)
                    LINE_START, GAP: begin
                        if ((r_state == LINE_START) && (inbound_data == ASCII_LBRACKET)) begin
                            r_state     <= LIGHTS;
                            r_light_idx <= '0;
                            r_mask      <= '0;
                        end else if ((r_state == GAP) && (inbound_data == ASCII_LPAREN)) begin
                            r_state <= BUTTON;
                            r_mask  <= '0;
                        end else if (inbound_data == ASCII_LBRACE) begin
                            r_state <= JOLTAGE;
                        end else if (inbound_data == ASCII_LF) begin
                            r_state   <= LINE_START;
                            r_eol     <= r_emitted;
                            r_emitted <= 1'b0;
                            r_btn_cnt <= 8'd0;
                        end else if ((inbound_data != ASCII_SPACE) && (inbound_data != ASCII_CR)) begin
                            r_err <= 1'b1;
                        end
                    end
                    LIGHTS: begin
                        if ((inbound_data == ASCII_HASH) || (inbound_data == ASCII_DOT)) begin
                            if (r_light_idx < LIGHT_LIMIT) begin
                                if (inbound_data == ASCII_HASH) begin
                                    r_mask <= r_mask | w_light_bit;
                                end
                                r_light_idx <= r_light_idx + IDX_W'(1);
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else if (inbound_data == ASCII_RBRACKET) begin
                            r_wvld    <= 1'b1;
                            r_wdat    <= r_mask;
                            r_emitted <= 1'b1;
                            r_state   <= GAP;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    BUTTON: begin
                        if ((inbound_data == ASCII_COMMA) || (inbound_data == ASCII_RPAREN)) begin
                            r_mask <= r_mask | w_index_bit;
                            if (!w_index_ok) begin
                                r_err <= 1'b1;
                            end
                            if (inbound_data == ASCII_RPAREN) begin
                                r_wvld    <= 1'b1;
                                r_wdat    <= r_mask | w_index_bit;
                                r_emitted <= 1'b1;
                                r_state   <= GAP;
                                if (r_btn_cnt != 8'hFF) begin
                                    r_btn_cnt <= r_btn_cnt + 8'd1;
                                end
                                if (r_btn_cnt >= BTN_LIMIT) begin
                                    r_err <= 1'b1;
                                end
                            end
                        end else if (!w_is_digit) begin
                            r_err <= 1'b1;
                        end
                    end
                    JOLTAGE: begin
                        if (inbound_data == ASCII_RBRACE) begin
                            r_state <= GAP;
                        end else if (!w_is_digit && (inbound_data != ASCII_COMMA)) begin
                            r_err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
                // final byte: close any open line, then report end of file and park
                if (inbound_last) begin
                    r_state <= DONE;
                    if (w_line_open) begin
                        if (w_emit_word) begin
                            r_eol_pend <= 1'b1;
                        end else begin
                            r_eol      <= 1'b1;
                            r_eof_pend <= 1'b1;
                        end
                    end else begin
                        r_eof <= 1'b1;
                    end
                end
            end
        end
    end

    assign end_of_file  = r_eof;
    assign end_of_line  = r_eol;
    assign wiring_valid = r_wvld;
    assign wiring_data  = r_wdat;
    assign decode_error = r_err;

endmodule

// File: tb/tb_machine_line_decoder.sv
// Directed, table-driven bench for machine_line_decoder.
module tb_machine_line_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       inbound_valid;
    logic [7:0] inbound_data;
    logic       inbound_last;
    logic       end_of_file;
    logic       end_of_line;
    logic       wiring_valid;
    logic [9:0] wiring_data;
    logic       decode_error;

    always #5 clk = ~clk;

    machine_line_decoder #(
        .MAX_WIRING_WIDTH   (10),
        .MAX_BUTTON_WIRINGS (13)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inbound_valid (inbound_valid),
        .inbound_data  (inbound_data),
        .inbound_last  (inbound_last),
        .end_of_file   (end_of_file),
        .end_of_line   (end_of_line),
        .wiring_valid  (wiring_valid),
        .wiring_data   (wiring_data),
        .decode_error  (decode_error)
    );

    typedef struct packed {
        logic         last;
        logic         gaps;
        logic [4:0]   n_words;
        logic [159:0] words;    // word k at bits [k*10 +: 10]
        logic [1:0]   n_eol;
        logic         n_eof;
        logic         err;
    } vec_t;

    localparam int NVEC = 10;
    vec_t  tbl [NVEC];
    string txt [NVEC];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int collide  = 0;
    int last_acc = 0;

    logic [9:0] q_word[$];
    int         q_word_cyc[$];
    int         q_eol_cyc[$];
    int         q_eof_cyc[$];
    int         q_mark[$];
    int         q_nl[$];

    always @(posedge clk) cyc <= cyc + 1;

    // record every output event with the cycle of the edge that produced it
    always @(negedge clk) begin
        if (wiring_valid) begin
            q_word.push_back(wiring_data);
            q_word_cyc.push_back(cyc);
        end
        if (end_of_line) q_eol_cyc.push_back(cyc);
        if (end_of_file) q_eof_cyc.push_back(cyc);
        if (wiring_valid && end_of_line) collide++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_queues();
        q_word.delete();
        q_word_cyc.delete();
        q_eol_cyc.delete();
        q_eof_cyc.delete();
        q_mark.delete();
        q_nl.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        inbound_valid = 1'b0;
        inbound_last  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_queues();
    endtask

    task automatic send(input logic [7:0] b, input bit is_last, input bit gaps);
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            @(negedge clk);
            inbound_valid = 1'b0;
            inbound_last  = 1'b0;
        end
        @(negedge clk);
        inbound_valid = 1'b1;
        inbound_data  = b;
        inbound_last  = is_last;
        last_acc      = cyc + 1;
        if ((b == 8'h5D) || (b == 8'h29)) q_mark.push_back(last_acc);
        if (b == 8'h0A) q_nl.push_back(last_acc);
    endtask

    task automatic run_text(input string s, input bit is_last, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], is_last && (i == s.len() - 1), gaps);
        end
        @(negedge clk);
        inbound_valid = 1'b0;
        inbound_last  = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        string s13;
        string s14;
        int    a;
        logic [31:0] got;
        logic [31:0] want;

        rst           = 1'b1;
        inbound_valid = 1'b0;
        inbound_data  = 8'h00;
        inbound_last  = 1'b0;

        s13 = "[.]";
        repeat (13) s13 = {s13, " (0)"};
        s14 = {s13, " (0)\n"};
        s13 = {s13, "\n"};

        txt[0] = "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n";
        tbl[0] = '{last: 1'b0, gaps: 1'b0, n_words: 5'd7,
                   words: 160'({10'h003, 10'h005, 10'h00C, 10'h004, 10'h00A, 10'h008, 10'h006}),
                   n_eol: 2'd1, n_eof: 1'b0, err: 1'b0};
        txt[1] = txt[0];
        tbl[1] = tbl[0];
        tbl[1].gaps = 1'b1;
        txt[2] = "\n\n[#] (0)\n";
        tbl[2] = '{last: 1'b1, gaps: 1'b0, n_words: 5'd2, words: 160'({10'h001, 10'h001}),
                   n_eol: 2'd1, n_eof: 1'b1, err: 1'b0};
        txt[3] = "[##########] (9)\n";
        tbl[3] = '{last: 1'b0, gaps: 1'b0, n_words: 5'd2, words: 160'({10'h200, 10'h3FF}),
                   n_eol: 2'd1, n_eof: 1'b0, err: 1'b0};
        txt[4] = "[###########] (9,0)\n";
        tbl[4] = '{last: 1'b0, gaps: 1'b0, n_words: 5'd2, words: 160'({10'h201, 10'h3FF}),
                   n_eol: 2'd1, n_eof: 1'b0, err: 1'b1};
        txt[5] = s13;
        tbl[5] = '{last: 1'b0, gaps: 1'b0, n_words: 5'd14, words: 160'({{13{10'h001}}, 10'h000}),
                   n_eol: 2'd1, n_eof: 1'b0, err: 1'b0};
        txt[6] = s14;
        tbl[6] = '{last: 1'b0, gaps: 1'b0, n_words: 5'd15, words: 160'({{14{10'h001}}, 10'h000}),
                   n_eol: 2'd1, n_eof: 1'b0, err: 1'b1};
        txt[7] = "[#] (12)\n";
        tbl[7] = '{last: 1'b0, gaps: 1'b0, n_words: 5'd2, words: 160'({10'h000, 10'h001}),
                   n_eol: 2'd1, n_eof: 1'b0, err: 1'b1};
        txt[8] = "[#x] (0)\n";
        tbl[8] = '{last: 1'b0, gaps: 1'b0, n_words: 5'd2, words: 160'({10'h001, 10'h001}),
                   n_eol: 2'd1, n_eof: 1'b0, err: 1'b1};
        txt[9] = "(3)\n";
        tbl[9] = '{last: 1'b0, gaps: 1'b0, n_words: 5'd0, words: 160'd0,
                   n_eol: 2'd0, n_eof: 1'b0, err: 1'b1};

        // reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_eof", 32'(end_of_file), 32'd0);
        check("rst_eol", 32'(end_of_line), 32'd0);
        check("rst_wvld", 32'(wiring_valid), 32'd0);
        check("rst_wdat", 32'(wiring_data), 32'd0);
        check("rst_err", 32'(decode_error), 32'd0);

        // table-driven lines
        for (int t = 0; t < NVEC; t++) begin
            do_reset();
            run_text(txt[t], tbl[t].last, tbl[t].gaps);
            check($sformatf("v%0d_nwords", t), 32'(q_word.size()), 32'(tbl[t].n_words));
            for (int k = 0; k < int'(tbl[t].n_words); k++) begin
                got  = (k < q_word.size()) ? 32'(q_word[k]) : 32'hDEAD;
                want = 32'(tbl[t].words[k*10 +: 10]);
                check($sformatf("v%0d_word%0d", t, k), got, want);
                got  = (k < q_word_cyc.size()) ? 32'(q_word_cyc[k]) : 32'hDEAD;
                want = (k < q_mark.size()) ? 32'(q_mark[k]) : 32'hBEEF;
                check($sformatf("v%0d_word%0d_cycle", t, k), got, want);
            end
            check($sformatf("v%0d_neol", t), 32'(q_eol_cyc.size()), 32'(tbl[t].n_eol));
            if ((tbl[t].n_eol != 0) && (q_eol_cyc.size() > 0) && (q_nl.size() > 0)) begin
                check($sformatf("v%0d_eol_cycle", t), 32'(q_eol_cyc[q_eol_cyc.size()-1]),
                      32'(q_nl[q_nl.size()-1]));
            end
            check($sformatf("v%0d_neof", t), 32'(q_eof_cyc.size()), 32'(tbl[t].n_eof));
            if ((tbl[t].n_eof != 0) && (q_eof_cyc.size() > 0)) begin
                check($sformatf("v%0d_eof_cycle", t), 32'(q_eof_cyc[0]), 32'(last_acc));
            end
            check($sformatf("v%0d_err", t), 32'(decode_error), 32'(tbl[t].err));
        end

        // error stays sticky through idle cycles until reset
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(decode_error), 32'd1);

        // unterminated final line: eol at +1, eof at +2, then input ignored
        do_reset();
        run_text("[#.] (1)\n[.#] (0) {1,2}", 1'b1, 1'b0);
        a = last_acc;
        run_text("[#] (0)\n", 1'b0, 1'b0);
        check("eof_nwords", 32'(q_word.size()), 32'd4);
        check("eof_word2", (q_word.size() > 2) ? 32'(q_word[2]) : 32'hDEAD, 32'h002);
        check("eof_word3", (q_word.size() > 3) ? 32'(q_word[3]) : 32'hDEAD, 32'h001);
        check("eof_neol", 32'(q_eol_cyc.size()), 32'd2);
        check("eof_eol_cycle", (q_eol_cyc.size() > 1) ? 32'(q_eol_cyc[1]) : 32'hDEAD, 32'(a));
        check("eof_neof", 32'(q_eof_cyc.size()), 32'd1);
        check("eof_eof_cycle", (q_eof_cyc.size() > 0) ? 32'(q_eof_cyc[0]) : 32'hDEAD, 32'(a + 1));
        check("eof_err", 32'(decode_error), 32'd0);

        // reset mid-line discards everything
        do_reset();
        run_text("[.#] (1,", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_wvld", 32'(wiring_valid), 32'd0);
        check("midrst_wdat", 32'(wiring_data), 32'd0);
        check("midrst_eol", 32'(end_of_line), 32'd0);
        check("midrst_eof", 32'(end_of_file), 32'd0);
        check("midrst_err", 32'(decode_error), 32'd0);
        rst = 1'b0;
        clear_queues();
        run_text("[#.] (0)\n", 1'b0, 1'b0);
        check("after_nwords", 32'(q_word.size()), 32'd2);
        check("after_word0", (q_word.size() > 0) ? 32'(q_word[0]) : 32'hDEAD, 32'h001);
        check("after_word1", (q_word.size() > 1) ? 32'(q_word[1]) : 32'hDEAD, 32'h001);
        check("after_neol", 32'(q_eol_cyc.size()), 32'd1);
        check("after_err", 32'(decode_error), 32'd0);

        check("eol_wvld_overlap", 32'(collide), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/machine_line_decoder.md
Name: machine_line_decoder

Overview:
Byte-stream parser for the day-10 puzzle input. It sits in front of the compute units and converts ASCII lines such as "[.##.] (3) (1,3) {3,5,4,7}" into the decoded line-contents interface: end_of_file, end_of_line, wiring_valid and wiring_data. Per line it emits the indicator-light target word first, then one mask word per button wiring. The joltage group is parsed for syntax and discarded.

Parameters:
MAX_WIRING_WIDTH, 10, width of light/button masks; maximum light count and button index + 1
MAX_BUTTON_WIRINGS, 13, maximum button groups per line; used only for overflow checking

Ports:
clk  input  1  single clock
rst  input  1  synchronous, active-high reset
inbound_valid  input  1  inbound_data carries a byte this cycle
inbound_data  input  8  ASCII byte
inbound_last  input  1  qualifies the final byte of the file (valid with inbound_valid)
end_of_file  output  1  one-cycle pulse after the whole input has been decoded
end_of_line  output  1  one-cycle pulse closing a non-empty line
wiring_valid  output  1  wiring_data holds a target word or a button mask
wiring_data  output  MAX_WIRING_WIDTH  mask; bit n = light n
decode_error  output  1  sticky error flag; cleared only by rst

Behaviour:
- All outputs are registered. Reset values: end_of_file=0, end_of_line=0, wiring_valid=0, wiring_data=0, decode_error=0. The FSM resets to LINE_START.
- Latency: the output caused by a byte appears exactly 1 cycle after that byte is accepted. The input is always accepted; there is no backpressure. Idle cycles (inbound_valid=0) leave state unchanged and outputs low, except wiring_data, which holds its last value.
- FSM states: LINE_START, LIGHTS, GAP, BUTTON, JOLTAGE, DONE.
- LINE_START and GAP:
  - '[' (LINE_START only) → LIGHTS, light index=0, mask=0.
  - '(' (GAP only) → BUTTON, mask=0, acc=0.
  - '{' → JOLTAGE.
  - ' ' and '\r' are ignored.
  - '\n' → LINE_START; end_of_line pulses only if the line emitted at least one word. Empty lines produce nothing.
- LIGHTS:
  - '#' sets mask[index] and increments index; '.' increments index only.
  - ']' emits wiring_valid with mask, then → GAP.
  - index reaching MAX_WIRING_WIDTH on a further '.'/'#' sets decode_error; the extra light is dropped.
- BUTTON:
  - Digits accumulate acc = acc*10 + d, saturating at 255.
  - ',' sets mask[acc] and clears acc.
  - ')' sets mask[acc] and emits the mask, then → GAP; the button counter increments.
  - acc ≥ MAX_WIRING_WIDTH sets decode_error; no bit is set.
  - Empty index (e.g. "()" or ",,") sets decode_error.
- JOLTAGE: digits and ',' are skipped; '}' → GAP.
- Any other byte in any state sets decode_error, is ignored, and the state is unchanged.
- A button count above MAX_BUTTON_WIRINGS in one line sets decode_error; the extra masks are still emitted.
- inbound_last:
  - The byte is processed normally.
  - If the line is still open with emitted words (no trailing '\n'), end_of_line pulses on cycle +1 and end_of_file on cycle +2.
  - Otherwise end_of_file pulses on cycle +1.
  - The FSM then → DONE, which ignores all input until rst.
- end_of_line and wiring_valid are never asserted in the same cycle.
- Line state (button counter, emitted flag) clears at each '\n'.
- rst mid-line discards partial state; no pulses are produced for the aborted line.

Decomposition:
- Package machine_pkg holds:
  - ASCII constants: '[', ']', '(', ')', '{', '}', ',', '.', '#', '\n', '\r', ' '.
  - decoder_state_t enum.
  - wiring_t typedef, parameterised via MAX_WIRING_WIDTH in the module.
- One sub-module is natural: ascii_decimal_accumulator (digit detect, acc*10+d, saturate, clear). Everything else stays flat.

Test Plan:
- "[.##.] (3) (1,3) (2) (2,3) (0,2) (0,1) {3,5,4,7}\n" → wiring_valid words 0x006, 0x008, 0x00A, 0x004, 0x00C, 0x005, 0x003 in order, then a single end_of_line pulse; decode_error=0.
- Two lines with no trailing newline, last byte '}' flagged inbound_last → end_of_line on cycle +1, end_of_file on cycle +2; further bytes produce no output.
- "\n\n[#] (0)\n" with inbound_last on the final '\n' → words 0x001, 0x001; exactly one end_of_line; end_of_file 1 cycle after the last byte.
- "[#] (12)\n" with MAX_WIRING_WIDTH=10 → word 0x001, then a button word 0x000; decode_error rises and stays 1 until rst.
- Random inbound_valid gaps (50% duty) on the first test line → identical word sequence and pulses, each 1 cycle after its causing byte.
- rst asserted after "[.#] (1," → all outputs 0 next cycle. A following "[#.] (0)\n" decodes to 0x001, 0x001, end_of_line, with no residue from the aborted line.
